// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall control slice.
// Holds the hazard FSM state encoding, the register-index width and the
// default data-memory wait timeout.
package pipe_pkg;

  localparam int REG_AW          = 5;
  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_lu_detect.sv
// Purely combinational load-use hazard compare between the instruction in ID
// and a load sitting in EX. x0 is never a real dependency. Kept separate so
// the forwarding unit can reuse the same compare.
module hazard_lu_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_MemRead,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              lu
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1 = id_use_rs1 & (id_rs1 == ex_rd);
  assign hit_rs2 = id_use_rs2 & (id_rs2 == ex_rd);
  assign lu      = ex_MemRead & (ex_rd != '0) & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage CPU.
// - load-use: one bubble into ID/EX while PC and IF/ID hold
// - EX redirect: flush IF/ID, bubble into ID/EX
// - outstanding data-memory access: freeze the whole pipeline, with a
//   timeout FSM (RUN/WAIT/ERR) and a sticky mem_err flag
// Priority is freeze > redirect > load-use. All outputs are forced low
// during reset and for the first cycle after it.
// Optional build macro HAZARD_PERF_EN adds lu_cnt/flush_cnt/freeze_cnt
// cycle counters for each priority branch.
module hazard_stall_ctrl #(
  parameter int REG_AW      = pipe_pkg::REG_AW,
  parameter int MEM_TIMEOUT = pipe_pkg::MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_MemRead,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              CLoad_Use,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              pipe_freeze,
  output logic              mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       lu_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       freeze_cnt
`endif
);

  import pipe_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  hz_state_t        state;
  hz_state_t        state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             rst_q;
  logic             active;
  logic             lu;
  logic             mw;
  logic             take_redirect;
  logic             take_lu;

  hazard_lu_detect #(
    .REG_AW (REG_AW)
  ) u_lu (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_MemRead (ex_MemRead),
    .ex_rd      (ex_rd),
    .lu         (lu)
  );

  // Outputs stay quiet while reset is asserted and for one cycle afterwards.
  assign active = ~rst & ~rst_q;

  // Memory wait only counts outside ERR; in ERR the pipeline runs on.
  assign mw            = active & mem_req & ~mem_ready & (state != ERR);
  assign take_redirect = active & ~mw & ex_redirect;
  assign take_lu       = active & ~mw & ~ex_redirect & lu;

  // Remember that reset was asserted last cycle.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Next-state logic for the memory-wait timeout FSM.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (mw) state_nx = WAIT;
      WAIT: begin
        if (mem_ready)                     state_nx = RUN;
        else if (mw && wait_cnt >= CNT_LAST) state_nx = ERR;
      end
      ERR:     state_nx = ERR;
      default: state_nx = RUN;
    endcase
  end

  // Wait-cycle counter: counts mw cycles, clears whenever the FSM is (re)entering RUN, saturates.
  always_ff @(posedge clk) begin
    if (rst)                                  wait_cnt <= '0;
    else if (state_nx == RUN)                 wait_cnt <= '0;
    else if (mw && wait_cnt != CNT_MAX)       wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky timeout flag, set on the WAIT->ERR transition.
  always_ff @(posedge clk) begin
    if (rst)                                  err_q <= 1'b0;
    else if (state == WAIT && state_nx == ERR) err_q <= 1'b1;
  end

  // Prioritised stall/flush outputs: freeze > redirect > load-use.
  always_comb begin
    CLoad_Use   = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (mw) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      pipe_freeze = 1'b1;
    end else if (take_redirect) begin
      ifid_flush = 1'b1;
      CLoad_Use  = 1'b1;
    end else if (take_lu) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      CLoad_Use  = 1'b1;
    end
  end

  assign mem_err = err_q & active;

`ifdef HAZARD_PERF_EN
  // Per-branch cycle counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt     <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (take_lu)       lu_cnt     <= lu_cnt + 32'd1;
      if (take_redirect) flush_cnt  <= flush_cnt + 32'd1;
      if (mw)            freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT = 4).
// Directed scenarios check fixed expected patterns; a randomized run checks
// every cycle against a cycle-level reference model.
module tb_hazard_stall_ctrl;
  import pipe_pkg::*;

  localparam int AW  = 5;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_MemRead, ex_redirect, mem_req, mem_ready;
  logic          CLoad_Use, pc_stall, ifid_stall, ifid_flush, pipe_freeze, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0]   lu_cnt, flush_cnt, freeze_cnt;
`endif
  logic [5:0]    outs;

  int n_pass = 0;
  int n_chk  = 0;

  // reference model state
  bit          m_err;
  bit          m_after;
  int          m_cnt;
  logic [31:0] m_lu, m_fl, m_fz;

  always #5 clk = ~clk;

  assign outs = {CLoad_Use, pc_stall, ifid_stall, ifid_flush, pipe_freeze, mem_err};

  hazard_stall_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_MemRead  (ex_MemRead),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .CLoad_Use   (CLoad_Use),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .pipe_freeze (pipe_freeze),
    .mem_err     (mem_err)
`ifdef HAZARD_PERF_EN
    ,
    .lu_cnt      (lu_cnt),
    .flush_cnt   (flush_cnt),
    .freeze_cnt  (freeze_cnt)
`endif
  );

  function automatic bit m_lu_hit();
    return ex_MemRead && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit m_mw();
    return !rst && !m_after && !m_err && mem_req && !mem_ready;
  endfunction

  // Expected {CLoad_Use,pc_stall,ifid_stall,ifid_flush,pipe_freeze,mem_err}
  function automatic logic [5:0] exp_out();
    bit act;
    act = !rst && !m_after;
    if (!act)             return 6'b000000;
    if (m_mw())           return {5'b01101, m_err};
    if (ex_redirect)      return {5'b10010, m_err};
    if (m_lu_hit())       return {5'b11100, m_err};
    return {5'b00000, m_err};
  endfunction

  // Advance one clock and update the model from the inputs held this cycle.
  task automatic tick();
    bit act;
    @(posedge clk);
    if (rst) begin
      m_err = 0; m_cnt = 0; m_after = 1;
      m_lu = 0; m_fl = 0; m_fz = 0;
    end else begin
      act = !m_after;
      if (m_mw()) begin
        m_fz = m_fz + 1;
        m_cnt = m_cnt + 1;
        if (m_cnt >= TMO) m_err = 1;
      end else begin
        if (act && ex_redirect) m_fl = m_fl + 1;
        else if (act && m_lu_hit()) m_lu = m_lu + 1;
        if (mem_ready && !m_err) m_cnt = 0;
      end
      m_after = 0;
    end
    #1;
  endtask

  task automatic drv(input logic r, input logic mr, input logic [AW-1:0] rd,
                     input logic u1, input logic [AW-1:0] s1,
                     input logic u2, input logic [AW-1:0] s2,
                     input logic redir, input logic mq, input logic mrdy);
    rst = r; ex_MemRead = mr; ex_rd = rd;
    id_use_rs1 = u1; id_rs1 = s1; id_use_rs2 = u2; id_rs2 = s2;
    ex_redirect = redir; mem_req = mq; mem_ready = mrdy;
  endtask

  task automatic do_reset();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    // hazard stimulus held through reset
    drv(1, 1, 5, 1, 5, 0, 0, 0, 1, 0);
    tick();
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b0) $display("FAIL reset_during outs=%b exp=%b", outs, 6'b0);
    else n_pass++;
    n_chk++;
    if (dut.state !== RUN) $display("FAIL reset_state got=%0d exp=%0d", dut.state, RUN);
    else n_pass++;
    tick();
    rst = 0;
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b0) $display("FAIL reset_after outs=%b exp=%b", outs, 6'b0);
    else n_pass++;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add x6,x5,x1 in ID
    drv(0, 1, 5, 1, 5, 1, 1, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b111000) $display("FAIL lu_stall outs=%b exp=%b", outs, 6'b111000);
    else n_pass++;
    tick();
    // bubble now in EX
    drv(0, 0, 0, 1, 5, 1, 1, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b000000) $display("FAIL lu_one_bubble outs=%b exp=%b", outs, 6'b000000);
    else n_pass++;
    tick();
    drv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b000000) $display("FAIL lu_x0 outs=%b exp=%b", outs, 6'b000000);
    else n_pass++;
    tick();
    drv(0, 1, 7, 0, 7, 1, 7, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b111000) $display("FAIL lu_rs2 outs=%b exp=%b", outs, 6'b111000);
    else n_pass++;
    tick();
    drv(0, 1, 7, 0, 7, 0, 7, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b000000) $display("FAIL lu_unused outs=%b exp=%b", outs, 6'b000000);
    else n_pass++;
    tick();
  endtask

  task automatic test_redirect();
    drv(0, 1, 5, 1, 5, 0, 0, 1, 0, 0);
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b100100) $display("FAIL redirect_over_lu outs=%b exp=%b", outs, 6'b100100);
    else n_pass++;
    tick();
    drv(0, 1, 5, 1, 5, 0, 0, 1, 1, 1);
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b100100) $display("FAIL redirect_zero_wait outs=%b exp=%b", outs, 6'b100100);
    else n_pass++;
    tick();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      // redirect and load-use present but must be deferred
      drv(0, 1, 5, 1, 5, 0, 0, (i == 1), 1, 0);
      @(negedge clk);
      n_chk++;
      if (outs !== 6'b011010) $display("FAIL mem_wait_c%0d outs=%b exp=%b", i, outs, 6'b011010);
      else n_pass++;
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b000000) $display("FAIL mem_wait_done outs=%b exp=%b", outs, 6'b000000);
    else n_pass++;
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (dut.state !== RUN || dut.wait_cnt !== 5'd0)
      $display("FAIL mem_wait_run state=%0d cnt=%0d exp_state=%0d exp_cnt=0", dut.state, dut.wait_cnt, RUN);
    else n_pass++;
    tick();
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      n_chk++;
      if (outs !== 6'b000000 || dut.state !== RUN)
        $display("FAIL zero_wait_c%0d outs=%b state=%0d exp outs=000000 state=0", i, outs, dut.state);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TMO; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      n_chk++;
      if (outs !== 6'b011010) $display("FAIL timeout_freeze_c%0d outs=%b exp=%b", i, outs, 6'b011010);
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b000001) $display("FAIL timeout_err outs=%b exp=%b", outs, 6'b000001);
    else n_pass++;
    tick();
    // load-use still handled while in ERR
    drv(0, 1, 3, 1, 3, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b111001) $display("FAIL timeout_lu outs=%b exp=%b", outs, 6'b111001);
    else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b000001) $display("FAIL timeout_sticky outs=%b exp=%b", outs, 6'b000001);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    @(negedge clk);
    n_chk++;
    if (dut.state !== WAIT || outs !== 6'b011010)
      $display("FAIL midwait_pre state=%0d outs=%b exp state=1 outs=011010", dut.state, outs);
    else n_pass++;
    rst = 1;
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b000000) $display("FAIL midwait_rst outs=%b exp=%b", outs, 6'b000000);
    else n_pass++;
    tick();
    rst = 0;
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b000000 || dut.state !== RUN)
      $display("FAIL midwait_after outs=%b state=%0d exp outs=000000 state=0", outs, dut.state);
    else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if (outs !== 6'b011010) $display("FAIL midwait_resume outs=%b exp=%b", outs, 6'b011010);
    else n_pass++;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    do_reset();
    drv(0, 1, 5, 1, 5, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drv(0, 1, 5, 1, 5, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (lu_cnt !== 32'd1 || flush_cnt !== 32'd1 || freeze_cnt !== 32'd3)
      $display("FAIL perf_counts lu=%0d flush=%0d freeze=%0d exp 1/1/3", lu_cnt, flush_cnt, freeze_cnt);
    else n_pass++;
    tick();
  endtask
`endif

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      drv(($urandom_range(0, 99) < 3),
          ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 35),
          ($urandom_range(0, 99) < 55));
      @(negedge clk);
      n_chk++;
      if (outs !== exp_out()) begin
        if (bad < 10) $display("FAIL rand_c%0d outs=%b exp=%b", i, outs, exp_out());
        bad++;
      end else n_pass++;
`ifdef HAZARD_PERF_EN
      n_chk++;
      if (lu_cnt !== m_lu || flush_cnt !== m_fl || freeze_cnt !== m_fz) begin
        if (bad < 10) $display("FAIL rand_perf_c%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                               i, lu_cnt, flush_cnt, freeze_cnt, m_lu, m_fl, m_fz);
        bad++;
      end else n_pass++;
`endif
      tick();
    end
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_err = 0; m_after = 1; m_cnt = 0; m_lu = 0; m_fl = 0; m_fz = 0;
    tick();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_zero_wait();
    test_timeout();
    test_reset_mid_wait();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
